// File: rtl/led_pwm_driver_if.sv
// Avalon-MM slave bus for the LED PWM driver register file (4 words, readLatency 0).
interface led_pwm_driver_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/led_pwm_driver.sv
// Drives LED pins from a PIO pattern with global PWM brightness and optional blink.
// Build option LED_FADE_EN: duty_active ramps one step per PWM period toward DUTY.
module led_pwm_driver #(
    parameter int WIDTH       = 10,
    parameter int PRESCALE    = 195,
    parameter int BLINK_RESET = 500
) (
    input  logic             clk,
    input  logic             reset,
    led_pwm_driver_if.slave  bus,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] led_out
);

    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [TW-1:0]    r_tick_cnt;
    logic [7:0]       r_pwm_cnt;
    logic [7:0]       r_duty;
    logic [1:0]       r_ctrl;
    logic [15:0]      r_blink_period;
    logic [15:0]      r_blink_cnt;
    logic             r_blink_phase;
    logic [7:0]       r_duty_active;
    logic [WIDTH-1:0] r_pattern_q;
    logic [WIDTH-1:0] r_led;

    logic        w_wr;
    logic        w_bp_wr;
    logic        w_enable;
    logic        w_blink_en;
    logic        w_tick;
    logic        w_period_start;
    logic [15:0] w_blink_limit;
    logic [7:0]  w_duty_next;
    logic        w_unused;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_bp_wr        = w_wr && (bus.address == 2'd2);
    assign w_enable       = r_ctrl[0];
    assign w_blink_en     = r_ctrl[1];
    assign w_tick         = w_enable && (r_tick_cnt == TW'(PRESCALE - 1));
    assign w_period_start = w_tick && (r_pwm_cnt == 8'd255);
    // BLINK_PERIOD of 0 behaves as 1, i.e. toggle at every period start
    assign w_blink_limit  = (r_blink_period == 16'd0) ? 16'd0 : r_blink_period - 16'd1;
    assign w_unused       = ^bus.writedata[31:16];
    assign led_out        = r_led;

`ifdef LED_FADE_EN
    always_comb begin
        w_duty_next = r_duty_active;
        if (r_duty_active < r_duty)
            w_duty_next = r_duty_active + 8'd1;
        else if (r_duty_active > r_duty)
            w_duty_next = r_duty_active - 8'd1;
    end
`else
    assign w_duty_next = r_duty;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty         <= 8'h80;
            r_ctrl         <= 2'b01;
            r_blink_period <= 16'(BLINK_RESET);
        end else if (w_wr) begin
            case (bus.address)
                2'd0:    r_duty         <= bus.writedata[7:0];
                2'd1:    r_ctrl         <= bus.writedata[1:0];
                2'd2:    r_blink_period <= bus.writedata[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_enable) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= 8'd0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Pattern and duty only change at a period boundary so no runt pulse reaches the pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern_q   <= '0;
            r_duty_active <= 8'h80;
        end else if (!w_enable) begin
            r_pattern_q   <= pattern_in;
            r_duty_active <= r_duty;
        end else if (w_period_start) begin
            r_pattern_q   <= pattern_in;
            r_duty_active <= w_duty_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_blink_en) begin
            r_blink_cnt   <= 16'd0;
            r_blink_phase <= 1'b1;
        end else if (w_bp_wr) begin
            r_blink_cnt   <= 16'd0;
        end else if (w_period_start) begin
            if (r_blink_cnt == w_blink_limit) begin
                r_blink_cnt   <= 16'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_led <= '0;
        else if (w_enable && (r_pwm_cnt < r_duty_active) && r_blink_phase)
            r_led <= r_pattern_q;
        else
            r_led <= '0;
    end

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata[7:0]  = r_duty;
            2'd1: bus.readdata[1:0]  = r_ctrl;
            2'd2: bus.readdata[15:0] = r_blink_period;
            default: begin
                bus.readdata[7:0]        = r_duty_active;
                bus.readdata[8]          = r_blink_phase;
                bus.readdata[9 +: WIDTH] = r_pattern_q;
            end
        endcase
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver at PRESCALE=1 (one PWM step per clock, 256-clock periods).
module tb_led_pwm_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pattern_in;
    logic [9:0] led_out;
    int         total = 0;
    int         bad   = 0;

`ifdef LED_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    led_pwm_driver_if bus();

    led_pwm_driver #(.WIDTH(10), .PRESCALE(1), .BLINK_RESET(500)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.address    = a;
        bus.writedata  = v;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Starts just after a period-start edge; sample j reflects the pwm step j-1.
    task automatic run_period(input bit wr_en, input logic [1:0] wa, input logic [31:0] wd,
                              input bit pat_en, input logic [9:0] pv, input int at_j,
                              input logic [9:0] exp_val,
                              output int on_cnt, output int last_on, output int n_wrong);
        on_cnt = 0; last_on = 0; n_wrong = 0;
        for (int j = 1; j <= 256; j++) begin
            if (j == at_j) begin
                if (wr_en) begin
                    bus.address    = wa;
                    bus.writedata  = wd;
                    bus.chipselect = 1'b1;
                    bus.write_n    = 1'b0;
                end
                if (pat_en) pattern_in = pv;
            end
            cyc();
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            if (led_out !== 10'd0) begin
                on_cnt++;
                last_on = j;
                if (led_out !== exp_val) n_wrong++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        pattern_in = 10'h111;
        reset = 1'b1;
        cyc();
        cyc();
        total++; if (led_out !== 10'd0) begin bad++; $display("FAIL reset_led: got %h want 000", led_out); end
        rd(2'd0, d);
        total++; if (d !== 32'h80) begin bad++; $display("FAIL reset_duty: got %h want 80", d); end
        rd(2'd1, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_ctrl: got %h want 1", d); end
        rd(2'd2, d);
        total++; if (d !== 32'd500) begin bad++; $display("FAIL reset_blink_period: got %0d want 500", d); end
        rd(2'd3, d);
        total++; if (d !== 32'h180) begin bad++; $display("FAIL reset_status: got %h want 180", d); end
        reset = 1'b0;
    endtask

    task automatic test_first_periods();
        int on, last, nw;
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h111, on, last, nw);
        total++; if (on !== 0) begin bad++; $display("FAIL first_period_on: got %0d want 0", on); end
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h111, on, last, nw);
        total++; if (on !== 128 || last !== 128) begin bad++; $display("FAIL second_period_on: got on=%0d last=%0d want 128/128", on, last); end
        total++; if (nw !== 0) begin bad++; $display("FAIL second_period_value: got %0d wrong samples want 0", nw); end
    endtask

    task automatic test_duty_bounds();
        int on, last, nw;
        logic [31:0] d;
        run_period(1, 2'd0, 32'd0, 0, 10'd0, 41, 10'h111, on, last, nw);
        total++; if (on !== 128 || last !== 128) begin bad++; $display("FAIL duty0_old_period: got on=%0d last=%0d want 128/128", on, last); end
        rd(2'd3, d);
        total++; if (d[7:0] !== 8'd0) begin bad++; $display("FAIL duty0_active: got %h want 00", d[7:0]); end
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h111, on, last, nw);
        total++; if (on !== 0) begin bad++; $display("FAIL duty0_period: got on=%0d want 0", on); end
        run_period(1, 2'd0, 32'd255, 0, 10'd0, 41, 10'h111, on, last, nw);
        total++; if (on !== 0) begin bad++; $display("FAIL duty255_old_period: got on=%0d want 0", on); end
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h111, on, last, nw);
        total++; if (on !== 255 || last !== 255 || nw !== 0) begin bad++; $display("FAIL duty255_period: got on=%0d last=%0d wrong=%0d want 255/255/0", on, last, nw); end
    endtask

    task automatic test_pattern_boundary();
        int on, last, nw;
        logic [31:0] d;
        run_period(1, 2'd0, 32'h80, 1, 10'h3FF, 5, 10'h111, on, last, nw);
        run_period(0, 2'd0, 0, 1, 10'h001, 41, 10'h3FF, on, last, nw);
        total++; if (on !== 128 || last !== 128 || nw !== 0) begin bad++; $display("FAIL pattern_hold: got on=%0d last=%0d wrong=%0d want 128/128/0", on, last, nw); end
        rd(2'd3, d);
        total++; if (d[18:9] !== 10'h001) begin bad++; $display("FAIL pattern_q_load: got %h want 001", d[18:9]); end
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h001, on, last, nw);
        total++; if (on !== 128 || nw !== 0) begin bad++; $display("FAIL pattern_new: got on=%0d wrong=%0d want 128/0", on, last); end
    endtask

    task automatic test_blink();
        int on, last, nw;
        int exp_on[11];
        logic [31:0] d;
        exp_on = '{128, 128, 128, 0, 0, 128, 128, 0, 128, 0, 128};
        for (int p = 0; p < 11; p++) begin
            case (p)
                0:  run_period(1, 2'd2, 32'd2, 0, 10'd0, 10, 10'h001, on, last, nw);
                1:  run_period(1, 2'd1, 32'd3, 0, 10'd0, 10, 10'h001, on, last, nw);
                6:  run_period(1, 2'd2, 32'd0, 0, 10'd0, 10, 10'h001, on, last, nw);
                10: run_period(1, 2'd1, 32'd1, 0, 10'd0, 10, 10'h001, on, last, nw);
                default: run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h001, on, last, nw);
            endcase
            total++; if (on !== exp_on[p] || nw !== 0) begin bad++; $display("FAIL blink_period%0d: got on=%0d wrong=%0d want %0d/0", p, on, nw, exp_on[p]); end
            if (p == 2) begin
                rd(2'd3, d);
                total++; if (d[8] !== 1'b0) begin bad++; $display("FAIL blink_phase_off: got %b want 0", d[8]); end
            end
        end
    endtask

    task automatic test_enable();
        int on, last, nw;
        logic [31:0] d;
        repeat (50) cyc();
        wr(2'd1, 32'd0);
        cyc();
        total++; if (led_out !== 10'd0) begin bad++; $display("FAIL disable_led: got %h want 000", led_out); end
        pattern_in = 10'h2A5;
        cyc();
        rd(2'd3, d);
        total++; if (d[18:9] !== 10'h2A5) begin bad++; $display("FAIL disable_transparent: got %h want 2a5", d[18:9]); end
        wr(2'd0, 32'h40);
        cyc();
        rd(2'd3, d);
        total++; if (d[7:0] !== 8'h40) begin bad++; $display("FAIL disable_duty_load: got %h want 40", d[7:0]); end
        total++; if (led_out !== 10'd0) begin bad++; $display("FAIL disable_led_hold: got %h want 000", led_out); end
        wr(2'd1, 32'd1);
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h2A5, on, last, nw);
        total++; if (on !== 64 || last !== 64 || nw !== 0) begin bad++; $display("FAIL reenable_period: got on=%0d last=%0d wrong=%0d want 64/64/0", on, last, nw); end
    endtask

    task automatic test_reset_mid();
        int on, last, nw;
        logic [31:0] d;
        repeat (40) cyc();
        total++; if (led_out !== 10'h2A5) begin bad++; $display("FAIL pre_reset_led: got %h want 2a5", led_out); end
        reset = 1'b1;
        cyc();
        total++; if (led_out !== 10'd0) begin bad++; $display("FAIL mid_reset_led: got %h want 000", led_out); end
        rd(2'd0, d);
        total++; if (d !== 32'h80) begin bad++; $display("FAIL mid_reset_duty: got %h want 80", d); end
        rd(2'd2, d);
        total++; if (d !== 32'd500) begin bad++; $display("FAIL mid_reset_blink_period: got %0d want 500", d); end
        rd(2'd3, d);
        total++; if (d !== 32'h180) begin bad++; $display("FAIL mid_reset_status: got %h want 180", d); end
        reset = 1'b0;
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h2A5, on, last, nw);
        total++; if (on !== 0) begin bad++; $display("FAIL post_reset_first: got on=%0d want 0", on); end
        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h2A5, on, last, nw);
        total++; if (on !== 128 || nw !== 0) begin bad++; $display("FAIL post_reset_second: got on=%0d wrong=%0d want 128/0", on, nw); end
    endtask

    task automatic test_fade();
        int on, last, nw;
        logic [31:0] d;
        logic [7:0] exp_seq[4];
        exp_seq = FADE ? '{8'd1, 8'd2, 8'd3, 8'd3} : '{8'd3, 8'd3, 8'd3, 8'd3};
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd0);
        cyc();
        wr(2'd1, 32'd1);
        rd(2'd3, d);
        total++; if (d[7:0] !== 8'd0) begin bad++; $display("FAIL fade_start: got %h want 00", d[7:0]); end
        for (int p = 0; p < 4; p++) begin
            if (p == 0) run_period(1, 2'd0, 32'd3, 0, 10'd0, 10, 10'h2A5, on, last, nw);
            else        run_period(0, 2'd0, 0, 0, 10'd0, 0, 10'h2A5, on, last, nw);
            rd(2'd3, d);
            total++; if (d[7:0] !== exp_seq[p]) begin bad++; $display("FAIL fade_step%0d: got %0d want %0d", p, d[7:0], exp_seq[p]); end
        end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        pattern_in     = 10'd0;
        reset          = 1'b1;
        test_reset();
        test_first_periods();
`ifndef LED_FADE_EN
        test_duty_bounds();
`endif
        test_pattern_boundary();
        test_blink();
        test_enable();
        test_reset_mid();
        test_fade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
